// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel-divided raster counters with registered sync, blanking and frame strobes.
module vga_sync_gen #(
  parameter int RESOLUTION_H    = 640,
  parameter int H_FRONT         = 80,
  parameter int H_SYNC          = 136,
  parameter int H_BACK          = 216,
  parameter int RESOLUTION_V    = 480,
  parameter int V_BOTTOM        = 1,
  parameter int V_SYNC          = 3,
  parameter int V_TOP           = 30,
  parameter int X_WIRE_WIDTH    = $clog2(RESOLUTION_H + H_FRONT + H_SYNC + H_BACK),
  parameter int Y_WIRE_WIDTH    = $clog2(RESOLUTION_V + V_BOTTOM + V_SYNC + V_TOP),
  parameter int PIX_DIV         = 1,
  parameter bit SYNC_POL        = 1'b0,
  parameter int FRAME_CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       sync_clr,
  output logic [X_WIRE_WIDTH-1:0]    hpos,
  output logic [Y_WIRE_WIDTH-1:0]    vpos,
  output logic                       display_on,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       pix_tick,
  output logic                       line_start,
  output logic                       frame_start,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt
);
  localparam int H_TOTAL = RESOLUTION_H + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = RESOLUTION_V + V_BOTTOM + V_SYNC + V_TOP;
  localparam int DIV_W = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [X_WIRE_WIDTH-1:0] H_LAST = X_WIRE_WIDTH'(H_TOTAL - 1);
  localparam logic [X_WIRE_WIDTH-1:0] H_VIS = X_WIRE_WIDTH'(RESOLUTION_H);
  localparam logic [X_WIRE_WIDTH-1:0] HS_LO = X_WIRE_WIDTH'(RESOLUTION_H + H_FRONT);
  localparam logic [X_WIRE_WIDTH-1:0] HS_HI = X_WIRE_WIDTH'(RESOLUTION_H + H_FRONT + H_SYNC - 1);
  localparam logic [Y_WIRE_WIDTH-1:0] V_LAST = Y_WIRE_WIDTH'(V_TOTAL - 1);
  localparam logic [Y_WIRE_WIDTH-1:0] V_VIS = Y_WIRE_WIDTH'(RESOLUTION_V);
  localparam logic [Y_WIRE_WIDTH-1:0] VS_LO = Y_WIRE_WIDTH'(RESOLUTION_V + V_BOTTOM);
  localparam logic [Y_WIRE_WIDTH-1:0] VS_HI = Y_WIRE_WIDTH'(RESOLUTION_V + V_BOTTOM + V_SYNC - 1);

  logic [DIV_W-1:0]           div_q, div_d;
  logic [X_WIRE_WIDTH-1:0]    hpos_q, hpos_d;
  logic [Y_WIRE_WIDTH-1:0]    vpos_q, vpos_d;
  logic                       display_on_q, display_on_d;
  logic                       hsync_q, hsync_d;
  logic                       vsync_q, vsync_d;
  logic                       pix_tick_q, pix_tick_d;
  logic                       line_start_q, line_start_d;
  logic                       frame_start_q, frame_start_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic                       adv, h_wrap;

  // Decoded outputs are computed from the next counter values so they share the counters' register stage.
  always_comb begin
    adv           = enable && div_q == DIV_LAST;
    h_wrap        = adv && hpos_q == H_LAST;
    div_d         = enable ? (adv ? '0 : div_q + 1'b1) : div_q;
    hpos_d        = adv ? (h_wrap ? '0 : hpos_q + 1'b1) : hpos_q;
    vpos_d        = h_wrap ? (vpos_q == V_LAST ? '0 : vpos_q + 1'b1) : vpos_q;
    display_on_d  = hpos_d < H_VIS && vpos_d < V_VIS;
    hsync_d       = (hpos_d >= HS_LO && hpos_d <= HS_HI) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (vpos_d >= VS_LO && vpos_d <= VS_HI) ? SYNC_POL : ~SYNC_POL;
    pix_tick_d    = adv;
    line_start_d  = h_wrap;
    frame_start_d = h_wrap && vpos_d == '0;
    frame_cnt_d   = frame_cnt_q + FRAME_CNT_WIDTH'(frame_start_d);
    if (sync_clr) begin
      div_d         = '0;
      hpos_d        = H_LAST;
      vpos_d        = V_LAST;
      display_on_d  = 1'b0;
      hsync_d       = ~SYNC_POL;
      vsync_d       = ~SYNC_POL;
      pix_tick_d    = 1'b0;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      frame_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q         <= '0;
      hpos_q        <= H_LAST;
      vpos_q        <= V_LAST;
      display_on_q  <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      pix_tick_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      div_q         <= div_d;
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      display_on_q  <= display_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      pix_tick_q    <= pix_tick_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign display_on  = display_on_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign pix_tick    = pix_tick_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of a full-size timing generator and a tiny divided one.
module tb_vga_sync_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst_n, a_en, a_clr;
  logic [10:0] a_hpos;
  logic [9:0] a_vpos;
  logic a_disp, a_hs, a_vs, a_pix, a_ls, a_fs;
  logic [7:0] a_fc;

  logic b_rst_n, b_en, b_clr;
  logic [3:0] b_hpos;
  logic [2:0] b_vpos;
  logic b_disp, b_hs, b_vs, b_pix, b_ls, b_fs;
  logic [1:0] b_fc;

  vga_sync_gen dut_a (
    .clk(clk), .reset_n(a_rst_n), .enable(a_en), .sync_clr(a_clr),
    .hpos(a_hpos), .vpos(a_vpos), .display_on(a_disp), .hsync(a_hs), .vsync(a_vs),
    .pix_tick(a_pix), .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc)
  );

  // 15x8 raster (hsync on 10..12, vsync on lines 5..6), four clocks per pixel, 2-bit frame counter
  vga_sync_gen #(
    .RESOLUTION_H(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .RESOLUTION_V(4), .V_BOTTOM(1), .V_SYNC(2), .V_TOP(1),
    .PIX_DIV(4), .FRAME_CNT_WIDTH(2)
  ) dut_b (
    .clk(clk), .reset_n(b_rst_n), .enable(b_en), .sync_clr(b_clr),
    .hpos(b_hpos), .vpos(b_vpos), .display_on(b_disp), .hsync(b_hs), .vsync(b_vs),
    .pix_tick(b_pix), .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    int n;
    int hpos;
    int vpos;
    int disp;
    int hs;
    int ls;
    int fs;
    int fc;
  } vec_t;

  vec_t tbl[11];

  task automatic a_state(input string tag, input int h, input int v, input int d, input int hs,
                         input int pix, input int ls, input int fs, input int fc);
    check({tag, ".hpos"}, int'(a_hpos), h);
    check({tag, ".vpos"}, int'(a_vpos), v);
    check({tag, ".disp"}, int'(a_disp), d);
    check({tag, ".hsync"}, int'(a_hs), hs);
    check({tag, ".pix"}, int'(a_pix), pix);
    check({tag, ".ls"}, int'(a_ls), ls);
    check({tag, ".fs"}, int'(a_fs), fs);
    check({tag, ".fc"}, int'(a_fc), fc);
  endtask

  initial begin
    int idx, hs_low, ticks, cyc, fs_seen, last, vs_n, hs_n, ds_n, ls_n, bad;
    tbl[0]  = '{1,    0,    0, 1, 1, 1, 1, 1};
    tbl[1]  = '{2,    1,    0, 1, 1, 0, 0, 1};
    tbl[2]  = '{640,  639,  0, 1, 1, 0, 0, 1};
    tbl[3]  = '{641,  640,  0, 0, 1, 0, 0, 1};
    tbl[4]  = '{720,  719,  0, 0, 1, 0, 0, 1};
    tbl[5]  = '{721,  720,  0, 0, 0, 0, 0, 1};
    tbl[6]  = '{856,  855,  0, 0, 0, 0, 0, 1};
    tbl[7]  = '{857,  856,  0, 0, 1, 0, 0, 1};
    tbl[8]  = '{1072, 1071, 0, 0, 1, 0, 0, 1};
    tbl[9]  = '{1073, 0,    1, 1, 1, 1, 0, 1};
    tbl[10] = '{1373, 300,  1, 1, 1, 0, 0, 1};
    a_rst_n = 0; a_en = 1; a_clr = 0;
    b_rst_n = 0; b_en = 1; b_clr = 0;
    #12;
    a_state("a_reset", 1071, 513, 0, 1, 0, 0, 0, 0);
    check("a_reset.vsync", int'(a_vs), 1);
    @(negedge clk) a_rst_n = 1;
    idx = 0; hs_low = 0; ticks = 0;
    for (int n = 1; n <= 1373; n++) begin
      @(posedge clk); #1;
      if (n <= 1072 && a_hs == 1'b0) hs_low++;
      if (a_pix) ticks++;
      if (a_vs != 1'b1) check("a_vsync_idle", int'(a_vs), 1);
      if (n == 1072) check("a_hsync_low_count", hs_low, 136);
      if (idx < 11 && n == tbl[idx].n) begin
        a_state($sformatf("a_vec%0d", idx), tbl[idx].hpos, tbl[idx].vpos, tbl[idx].disp,
                tbl[idx].hs, 1, tbl[idx].ls, tbl[idx].fs, tbl[idx].fc);
        idx++;
      end
    end
    check("a_tick_count", ticks, 1373);
    a_clr = 1;
    @(posedge clk); #1;
    a_state("a_clr", 1071, 513, 0, 1, 0, 0, 0, 0);
    a_clr = 0;
    @(posedge clk); #1;
    a_state("a_after_clr", 0, 0, 1, 1, 1, 1, 1, 1);
    repeat (800) @(posedge clk);
    #1;
    check("a_mid_hsync.hpos", int'(a_hpos), 800);
    check("a_mid_hsync.hsync", int'(a_hs), 0);
    a_rst_n = 0;
    #1;
    a_state("a_async", 1071, 513, 0, 1, 0, 0, 0, 0);
    check("a_async.vsync", int'(a_vs), 1);

    check("b_reset.hpos", int'(b_hpos), 14);
    check("b_reset.vpos", int'(b_vpos), 7);
    check("b_reset.fc", int'(b_fc), 0);
    @(negedge clk) b_rst_n = 1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      check($sformatf("b_div%0d.pix", e), int'(b_pix), (e % 4 == 0) ? 1 : 0);
      check($sformatf("b_div%0d.hpos", e), int'(b_hpos), e < 4 ? 14 : (e < 8 ? 0 : 1));
      if (e == 4) begin
        check("b_first.fs", int'(b_fs), 1);
        check("b_first.fc", int'(b_fc), 1);
      end
    end
    b_en = 0;
    for (int e = 0; e < 7; e++) begin
      @(posedge clk); #1;
      check("b_frozen.hpos", int'(b_hpos), 1);
      check("b_frozen.strobes", int'({b_pix, b_ls, b_fs}), 0);
    end
    b_en = 1;
    @(posedge clk); #1;
    check("b_resume1.pix", int'(b_pix), 0);
    check("b_resume1.hpos", int'(b_hpos), 1);
    @(posedge clk); #1;
    check("b_resume2.pix", int'(b_pix), 1);
    check("b_resume2.hpos", int'(b_hpos), 2);

    cyc = 0; fs_seen = 0; last = 0;
    vs_n = 0; hs_n = 0; ds_n = 0; ls_n = 0; bad = 0;
    while (fs_seen < 5 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (b_fs) begin
        check("b_fs_with_tick", int'(b_pix & b_ls), 1);
        check($sformatf("b_frame%0d.fc", fs_seen), int'(b_fc), (2 + fs_seen) % 4);
        if (fs_seen > 0) begin
          check("b_frame.period", cyc - last, 480);
          check("b_frame.vsync_ticks", vs_n, 30);
          check("b_frame.hsync_ticks", hs_n, 24);
          check("b_frame.disp_ticks", ds_n, 32);
          check("b_frame.line_starts", ls_n, 8);
          check("b_frame.blank_violations", bad, 0);
        end
        vs_n = 0; hs_n = 0; ds_n = 0; ls_n = 0; bad = 0;
        last = cyc;
        fs_seen++;
      end
      if (b_pix) begin
        if (!b_vs) vs_n++;
        if (!b_hs) hs_n++;
        if (b_disp) ds_n++;
        if (b_ls) ls_n++;
        if (b_disp && b_vpos >= 3'd4) bad++;
        if (!b_vs && (b_vpos < 3'd5 || b_vpos > 3'd6)) bad++;
      end
    end
    check("b_frames_seen", fs_seen, 5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator directly upstream of the `RGBMemory_top` framebuffer. It divides `clk` into a pixel tick and runs horizontal/vertical position counters. From those counters it drives `hpos`, `vpos` and `display_on` into the framebuffer read path, and `hsync`/`vsync` to the VGA connector. It also emits line/frame strobes and a frame counter for the write-side logic.

## Interface
Parameters:
- `RESOLUTION_H`, 640: visible pixels per line
- `H_FRONT`, 80: horizontal front porch (pixels)
- `H_SYNC`, 136: hsync pulse width (pixels)
- `H_BACK`, 216: horizontal back porch (pixels)
- `RESOLUTION_V`, 480: visible lines
- `V_BOTTOM`, 1: vertical front porch (lines)
- `V_SYNC`, 3: vsync width (lines)
- `V_TOP`, 30: vertical back porch (lines)
- `X_WIRE_WIDTH`, `$clog2(H_TOTAL)` = 11: `hpos` width
- `Y_WIRE_WIDTH`, `$clog2(V_TOTAL)` = 10: `vpos` width
- `PIX_DIV`, 1: clocks per pixel, ≥1
- `SYNC_POL`, 0: sync active level (0 = active-low)
- `FRAME_CNT_WIDTH`, 8: `frame_cnt` width

Derived values:
- H_TOTAL = RESOLUTION_H+H_FRONT+H_SYNC+H_BACK = 1072.
- V_TOTAL = RESOLUTION_V+V_BOTTOM+V_SYNC+V_TOP = 514.

Ports:
- `clk`  in  1: system clock
- `reset_n`  in  1: reset, asynchronous, active-low
- `enable`  in  1: run; 0 freezes all state
- `sync_clr`  in  1: synchronous restart to reset state
- `hpos`  out  X_WIRE_WIDTH: current column, 0..H_TOTAL-1
- `vpos`  out  Y_WIRE_WIDTH: current line, 0..V_TOTAL-1
- `display_on`  out  1: high when hpos<RESOLUTION_H and vpos<RESOLUTION_V
- `hsync`  out  1: horizontal sync, level per SYNC_POL
- `vsync`  out  1: vertical sync, level per SYNC_POL
- `pix_tick`  out  1: one-clock strobe marking a new pixel position this cycle
- `line_start`  out  1: strobe with pix_tick when hpos became 0
- `frame_start`  out  1: strobe with pix_tick when (hpos,vpos) became (0,0)
- `frame_cnt`  out  FRAME_CNT_WIDTH: frames started since reset, wraps

## Operation
- Divider `div` counts 0..PIX_DIV-1.
  - An advance happens on an edge where `enable`=1 and div==PIX_DIV-1; div then returns to 0.
  - Otherwise, if `enable`=1, div increments.
- On advance, `hpos` increments. When hpos==H_TOTAL-1 it wraps to 0, and `vpos` increments (wraps V_TOTAL-1→0).
- Sync windows:
  - `hsync` asserted for hpos in [RESOLUTION_H+H_FRONT, RESOLUTION_H+H_FRONT+H_SYNC-1] = [720,855].
  - `vsync` asserted for vpos in [RESOLUTION_V+V_BOTTOM, RESOLUTION_V+V_BOTTOM+V_SYNC-1] = [481,483].
  - Asserted level = SYNC_POL; inactive = ~SYNC_POL.
- All outputs are registered and updated on the same edge as the counters. `display_on`, `hsync` and `vsync` always correspond to the `hpos`/`vpos` present in the same cycle.
- `frame_cnt` increments (modulo 2^FRAME_CNT_WIDTH) on every advance into (0,0).
- `enable`=0:
  - div, counters, sync levels and `frame_cnt` hold.
  - `pix_tick`, `line_start`, `frame_start` are 0.
- Reset state (async `reset_n`=0, or `sync_clr`=1 at an edge):
  - hpos=H_TOTAL-1 (1071), vpos=V_TOTAL-1 (513), div=0.
  - display_on=0; hsync=vsync=~SYNC_POL.
  - pix_tick=line_start=frame_start=0; frame_cnt=0.
  - The first advance therefore lands on (0,0) with frame_start=1 and frame_cnt=1.
- `sync_clr` has priority over a coincident advance and over `enable`.
- `reset_n` deasserted mid-frame: counters restart from the reset state; no partial sync pulse persists.

## Timing
- Advance period: PIX_DIV clocks while `enable`=1.
- With PIX_DIV=1, the first advance occurs on the first rising edge after `reset_n` rises. pix_tick is then 1 every cycle.
- With PIX_DIV=N, the first advance occurs on the Nth rising edge after release. pix_tick is high 1 cycle in N.
- Strobes are one clock wide and coincide with pix_tick.
- Line period: 1072 advances. Frame period: 1072×514 = 551008 advances.
- Zero-cycle latency from counter value to decoded outputs (same register stage).

## Test plan
- Reset: hold reset_n=0 → hpos=1071, vpos=513, display_on=0, hsync=vsync=1, frame_cnt=0. First edge after release (PIX_DIV=1) → hpos=0, vpos=0, display_on=1, line_start=frame_start=1, frame_cnt=1.
- Line wrap: run 1072 ticks → hsync low exactly for hpos 720..855; display_on drops at hpos=640. At 1071→0, vpos increments to 1 and line_start=1 while frame_start=0.
- Frame wrap: run a full frame → vsync low only on lines 481..483; display_on=0 for all vpos≥480. Next frame_start occurs 551008 ticks after the previous one, with frame_cnt=2.
- Divider and enable (PIX_DIV=4): pix_tick every 4th clock. Drop `enable` for 7 clocks mid-line → hpos/div frozen, no strobes; resume with the same phase.
- sync_clr at hpos=300, vpos=200, coincident with an advance → next cycle shows the reset state (1071, 513, frame_cnt=0). The following advance gives (0,0) with frame_start.
- Async reset asserted mid-hsync (hpos=800) → hsync returns to 1 immediately, without waiting for a clock edge; all counters are at the reset state.
